// File: rtl/leiwand_rv32_ram_mp_pkg.sv
// Shared definitions for the multi-port RV32 RAM: controller states, access
// size codes, size-field width and small decode helpers.
package leiwand_rv32_ram_mp_pkg;

    // Index of the MSB needed to hold value v (0 for v <= 1).
    function automatic int unsigned high_bit_to_fit(input int unsigned v);
        return (v < 2) ? 0 : $clog2(v + 1) - 1;
    endfunction

    localparam int unsigned SIZE_W = high_bit_to_fit(4) + 1;

    localparam logic [SIZE_W-1:0] SIZE_BYTE = SIZE_W'(1);
    localparam logic [SIZE_W-1:0] SIZE_HALF = SIZE_W'(2);
    localparam logic [SIZE_W-1:0] SIZE_WORD = SIZE_W'(4);

    typedef enum logic [0:0] {
        STATE_INIT = 1'b0,
        STATE_RUN  = 1'b1
    } state_t;

    // Illegal size code or a size/alignment combination that cannot be served.
    function automatic logic size_align_err(input logic [SIZE_W-1:0] size,
                                            input logic [1:0] lo);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return lo[0];
            SIZE_WORD: return lo != 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

    // Byte-lane write mask for a naturally aligned access.
    function automatic logic [3:0] lane_mask(input logic [SIZE_W-1:0] size,
                                             input logic [1:0] lo);
        case (size)
            SIZE_BYTE: return 4'b0001 << lo;
            SIZE_HALF: return lo[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/leiwand_rv32_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, searching from the
// pointer; the pointer moves past the winner on every grant.
// Ports: i_clk, i_rst (sync, active high), req (per requester),
//        grant (one-hot), grant_idx (winner index), grant_valid.
module leiwand_rv32_rr_arbiter #(
    parameter  int unsigned NUM_PORTS = 2,
    localparam int unsigned PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] grant,
    output logic [PTR_W-1:0]     grant_idx,
    output logic                 grant_valid
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W:0]   cand;

    // First requester at or after the pointer, wrapping modulo NUM_PORTS.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand = (PTR_W+1)'(ptr_q) + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_PORTS)) begin
                cand = cand - (PTR_W+1)'(NUM_PORTS);
            end
            if (!grant_valid && req[cand[PTR_W-1:0]]) begin
                grant_valid              = 1'b1;
                grant_idx                = cand[PTR_W-1:0];
                grant[cand[PTR_W-1:0]]   = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else if (grant_valid) begin
            ptr_q <= (grant_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/leiwand_rv32_ram_mp.sv
// Multi-port word-organised RV32 RAM with pipelined Wishbone-style channels.
// One access per cycle via round-robin arbitration; ack one cycle after accept,
// with err flagging out-of-range, bad-size and misaligned accesses.
// Ports (per channel p, slice [p*32+:32] / [p]): i_addr, i_dat, o_dat, i_we,
//   i_stb, i_cyc, o_stall, o_ack, o_err, i_dat_wr_size (1/2/4 bytes).
//   i_clk, i_rst (synchronous, active high).
// Option: LEIWAND_RAM_INIT_ZERO_EN clears the memory word by word after reset.
module leiwand_rv32_ram_mp
    import leiwand_rv32_ram_mp_pkg::*;
#(
    parameter int unsigned MEM_WIDTH = 32,
    parameter int unsigned MEM_SIZE  = 1024,
    parameter int unsigned NUM_PORTS = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_PORTS*MEM_WIDTH-1:0] i_addr,
    input  logic [NUM_PORTS*MEM_WIDTH-1:0] i_dat,
    output logic [NUM_PORTS*MEM_WIDTH-1:0] o_dat,
    input  logic [NUM_PORTS-1:0]           i_we,
    input  logic [NUM_PORTS-1:0]           i_stb,
    input  logic [NUM_PORTS-1:0]           i_cyc,
    output logic [NUM_PORTS-1:0]           o_stall,
    output logic [NUM_PORTS-1:0]           o_ack,
    output logic [NUM_PORTS-1:0]           o_err,
    input  logic [NUM_PORTS*SIZE_W-1:0]    i_dat_wr_size
);

    localparam int unsigned MEM_HIGH_BIT = high_bit_to_fit(MEM_SIZE - 1);
    localparam int unsigned IDX_W        = MEM_HIGH_BIT + 1;
    localparam int unsigned PTR_W        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [MEM_WIDTH-1:0] mem [MEM_SIZE];

    state_t                   state_q, state_d;
    logic                     run;
    logic [NUM_PORTS-1:0]     req, arb_req, grant;
    logic [PTR_W-1:0]         grant_idx;
    logic                     grant_valid;
    logic [MEM_WIDTH-1:0]     sel_addr, sel_dat;
    logic                     sel_we;
    logic [SIZE_W-1:0]        sel_size;
    logic [IDX_W-1:0]         idx;
    logic                     acc_err, wr_en;
    logic [3:0]               wr_be;
    logic [MEM_WIDTH-1:0]     wr_data;
    logic [NUM_PORTS-1:0]     ack_q, err_q;
    logic [NUM_PORTS*MEM_WIDTH-1:0] dat_q;

    assign run     = (state_q == STATE_RUN) && !i_rst;
    assign req     = i_cyc & i_stb;
    assign arb_req = req & {NUM_PORTS{run}};
    assign o_stall = {NUM_PORTS{!run}} | (req & ~grant);

    leiwand_rv32_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .req         (arb_req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Route the granted channel's request onto the shared memory port.
    always_comb begin
        sel_addr = '0;
        sel_dat  = '0;
        sel_we   = 1'b0;
        sel_size = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (grant[p]) begin
                sel_addr = i_addr[p*MEM_WIDTH +: MEM_WIDTH];
                sel_dat  = i_dat[p*MEM_WIDTH +: MEM_WIDTH];
                sel_we   = i_we[p];
                sel_size = i_dat_wr_size[p*SIZE_W +: SIZE_W];
            end
        end
    end

    // Range check uses the whole word address so aliasing addresses are rejected.
    assign idx     = sel_addr[MEM_HIGH_BIT+2:2];
    assign acc_err = (sel_addr[MEM_WIDTH-1:2] >= (MEM_WIDTH-2)'(MEM_SIZE))
                   | size_align_err(sel_size, sel_addr[1:0]);
    assign wr_en   = grant_valid && sel_we && !acc_err;
    assign wr_be   = lane_mask(sel_size, sel_addr[1:0]);

    always_comb begin
        case (sel_size)
            SIZE_BYTE: wr_data = {4{sel_dat[7:0]}};
            SIZE_HALF: wr_data = {2{sel_dat[15:0]}};
            default:   wr_data = sel_dat;
        endcase
    end

`ifdef LEIWAND_RAM_INIT_ZERO_EN
    logic [IDX_W-1:0] clr_q;
    logic             clr_last;

    assign clr_last = (clr_q == IDX_W'(MEM_SIZE - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            clr_q <= '0;
        end else if (state_q == STATE_INIT) begin
            clr_q <= clr_q + IDX_W'(1);
        end
    end
`endif

    // Memory array: no reset, so contents survive i_rst.
    always_ff @(posedge i_clk) begin
`ifdef LEIWAND_RAM_INIT_ZERO_EN
        if (!i_rst && state_q == STATE_INIT) begin
            mem[clr_q] <= '0;
        end
`endif
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= STATE_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            STATE_INIT: begin
`ifdef LEIWAND_RAM_INIT_ZERO_EN
                if (clr_last) begin
                    state_d = STATE_RUN;
                end
`else
                state_d = STATE_RUN;
`endif
            end
            STATE_RUN: state_d = STATE_RUN;
            default:   state_d = STATE_INIT;
        endcase
    end

    // Completion: the read happens at the accept edge, so a preceding write is visible.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ack_q <= '0;
            err_q <= '0;
            dat_q <= '0;
        end else begin
            ack_q <= grant;
            err_q <= acc_err ? grant : '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                dat_q[p*MEM_WIDTH +: MEM_WIDTH] <= (grant[p] && !acc_err && !sel_we)
                                                   ? mem[idx] : '0;
            end
        end
    end

    // Reset drops an ack that is already on its way out.
    assign o_ack = ack_q & {NUM_PORTS{!i_rst}};
    assign o_err = err_q & {NUM_PORTS{!i_rst}};
    assign o_dat = i_rst ? '0 : dat_q;

endmodule

// File: tb/tb_leiwand_rv32_ram_mp.sv
// Directed bench for leiwand_rv32_ram_mp (2 ports, 1024 words).
module tb_leiwand_rv32_ram_mp;

    localparam int unsigned NP = 2;
    localparam int unsigned MS = 1024;
`ifdef LEIWAND_RAM_INIT_ZERO_EN
    localparam int unsigned INIT_CYC = MS;
`else
    localparam int unsigned INIT_CYC = 1;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [NP*32-1:0] addr, wdat, rdat;
    logic [NP-1:0]   we, stb, cyc, stall, ack, err;
    logic [NP*3-1:0] size;

    int n_tests = 0;
    int n_fail  = 0;

    leiwand_rv32_ram_mp #(.MEM_WIDTH(32), .MEM_SIZE(MS), .NUM_PORTS(NP)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_addr        (addr),
        .i_dat         (wdat),
        .o_dat         (rdat),
        .i_we          (we),
        .i_stb         (stb),
        .i_cyc         (cyc),
        .o_stall       (stall),
        .o_ack         (ack),
        .o_err         (err),
        .i_dat_wr_size (size)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int p, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] sz);
        addr[p*32 +: 32] = a;
        wdat[p*32 +: 32] = d;
        size[p*3 +: 3]   = sz;
        we[p]  = w;
        cyc[p] = 1'b1;
        stb[p] = 1'b1;
    endtask

    task automatic clr_req(input int p);
        cyc[p] = 1'b0;
        stb[p] = 1'b0;
        we[p]  = 1'b0;
    endtask

    // Single access on port p; returns the completion data/err sampled in the ack cycle.
    task automatic access(input string tag, input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] sz,
                          output logic [31:0] rd, output logic er);
        int n;
        n = 0;
        set_req(p, w, a, d, sz);
        #1;
        while (stall[p] && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_accept"}, 32'(n < 50), 32'd1);
        @(posedge clk);
        #1;
        clr_req(p);
        @(negedge clk);
        check({tag, "_ack"}, 32'(ack[p]), 32'd1);
        rd = rdat[p*32 +: 32];
        er = err[p];
    endtask

    task automatic wr(input string tag, input int p, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] sz, input logic exp_err);
        logic [31:0] rd;
        logic er;
        access(tag, p, 1'b1, a, d, sz, rd, er);
        check({tag, "_err"}, 32'(er), 32'(exp_err));
        check({tag, "_dat0"}, rd, 32'h0);
    endtask

    task automatic rd_chk(input string tag, input int p, input logic [31:0] a,
                          input logic [2:0] sz, input logic [31:0] exp_d, input logic exp_err);
        logic [31:0] rd;
        logic er;
        access(tag, p, 1'b0, a, 32'h0, sz, rd, er);
        check({tag, "_err"}, 32'(er), 32'(exp_err));
        check({tag, "_dat"}, rd, exp_d);
    endtask

    // Release reset and count cycles until the idle ports stop stalling.
    task automatic release_reset();
        int n;
        n = 0;
        rst = 1'b0;
        #1;
        while (stall != '0 && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("init_cycles", 32'(n), 32'(INIT_CYC));
    endtask

    initial begin
        int n_ack;
        logic [31:0] exp_word;
        rst = 1'b1;
        addr = '0; wdat = '0; we = '0; stb = '0; cyc = '0; size = '0;
        repeat (3) @(negedge clk);
        check("rst_stall", 32'(stall), 32'h3);
        check("rst_ack",   32'(ack),   32'h0);
        check("rst_err",   32'(err),   32'h0);
        check("rst_dat0",  rdat[31:0], 32'h0);
        check("rst_dat1",  rdat[63:32], 32'h0);
        release_reset();
        @(negedge clk);

        // Basic word write / read.
        wr("w_word", 0, 32'h10, 32'hDEADBEEF, 3'd4, 1'b0);
        rd_chk("r_word", 0, 32'h10, 3'd4, 32'hDEADBEEF, 1'b0);

        // Byte and half writes merge into the word.
        wr("w_zero", 0, 32'h10, 32'h0, 3'd4, 1'b0);
        wr("w_byte", 0, 32'h11, 32'hFFFFFFAA, 3'd1, 1'b0);
        wr("w_half", 0, 32'h12, 32'hFFFF1234, 3'd2, 1'b0);
        rd_chk("r_merge", 0, 32'h10, 3'd4, 32'h1234AA00, 1'b0);

        // Port1 access leaves the pointer at 0.
        rd_chk("r_p1", 1, 32'h10, 3'd4, 32'h1234AA00, 1'b0);

        // Simultaneous requests: port0 first, port1 one cycle later.
        set_req(0, 1'b1, 32'h20, 32'h11111111, 3'd4);
        set_req(1, 1'b1, 32'h24, 32'h22222222, 3'd4);
        #1;
        check("cont_stall0", 32'(stall), 32'h2);
        @(posedge clk);
        #1;
        clr_req(0);
        @(negedge clk);
        check("cont_ack0",   32'(ack),   32'h1);
        check("cont_stall1", 32'(stall), 32'h0);
        @(posedge clk);
        #1;
        clr_req(1);
        @(negedge clk);
        check("cont_ack1", 32'(ack), 32'h2);
        check("cont_err",  32'(err), 32'h0);
        @(negedge clk);
        check("cont_idle", 32'(ack), 32'h0);

        // Continuous requests on both ports: pointer is 0 so port0 wins first.
        n_ack = 0;
        set_req(0, 1'b0, 32'h10, 32'h0, 3'd4);
        set_req(1, 1'b0, 32'h20, 32'h0, 3'd4);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 8) begin
                clr_req(0);
                clr_req(1);
            end
            @(negedge clk);
            n_ack += $countones(ack);
            if (k % 2 == 1) begin
                check("burst_ack_p0", 32'(ack), 32'h1);
                check("burst_dat_p0", rdat[31:0], 32'h1234AA00);
            end else begin
                check("burst_ack_p1", 32'(ack), 32'h2);
                check("burst_dat_p1", rdat[63:32], 32'h11111111);
            end
        end
        @(negedge clk);
        n_ack += $countones(ack);
        check("burst_count", 32'(n_ack), 32'd8);
        rd_chk("r_p1_24", 1, 32'h24, 3'd4, 32'h22222222, 1'b0);

        // Error accesses leave memory untouched.
        wr("w_seed0", 0, 32'h0, 32'hCAFEF00D, 3'd4, 1'b0);
        wr("w_seed4", 0, 32'h4, 32'h55667788, 3'd4, 1'b0);
        rd_chk("e_misal_w", 0, 32'h02, 3'd4, 32'h0, 1'b1);
        wr("e_misal_h", 0, 32'h05, 32'h0000BEEF, 3'd2, 1'b1);
        wr("e_size3",   1, 32'h10, 32'hFFFFFFFF, 3'd3, 1'b1);
        wr("e_range",   0, MS * 4, 32'h0BADF00D, 3'd4, 1'b1);
        rd_chk("e_range_r", 1, MS * 4 + 4, 3'd4, 32'h0, 1'b1);
        rd_chk("chk_4",  0, 32'h4,  3'd4, 32'h55667788, 1'b0);
        rd_chk("chk_10", 0, 32'h10, 3'd4, 32'h1234AA00, 1'b0);
        rd_chk("chk_0",  1, 32'h0,  3'd4, 32'hCAFEF00D, 1'b0);
        rd_chk("r_half_ok", 0, 32'h12, 3'd2, 32'h1234AA00, 1'b0);

        // Reset right after an accepted write drops the ack.
        wr("w_seed34", 0, 32'h34, 32'h12345678, 3'd4, 1'b0);
        set_req(0, 1'b1, 32'h30, 32'h99999999, 3'd4);
        #1;
        check("mid_accept", 32'(stall), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        clr_req(0);
        @(negedge clk);
        check("mid_ack",   32'(ack),   32'h0);
        check("mid_stall", 32'(stall), 32'h3);
        // A request presented under reset must not write.
        set_req(0, 1'b1, 32'h34, 32'hBAD0BAD0, 3'd4);
        @(negedge clk);
        clr_req(0);
        release_reset();
        @(negedge clk);
`ifdef LEIWAND_RAM_INIT_ZERO_EN
        exp_word = 32'h0;
        rd_chk("post_30", 0, 32'h30, 3'd4, exp_word, 1'b0);
        rd_chk("post_34", 1, 32'h34, 3'd4, exp_word, 1'b0);
`else
        exp_word = 32'h99999999;
        rd_chk("post_30", 0, 32'h30, 3'd4, exp_word, 1'b0);
        exp_word = 32'h12345678;
        rd_chk("post_34", 1, 32'h34, 3'd4, exp_word, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/leiwand_rv32_ram_mp.md
Name: leiwand_rv32_ram_mp

Overview:
- Multi-port, parametrised successor of the single-port RV32 RAM, with NUM_PORTS pipelined Wishbone-style slave channels (e.g. instruction fetch plus load/store) onto one word-organised memory.
- A round-robin arbiter grants one access per cycle. Ack returns exactly one cycle after acceptance.
- Adds access-error reporting for misaligned, out-of-range and bad-size accesses.
- Sits between the leiwand_rv32 core bus masters and on-chip memory.

Parameters:
- MEM_WIDTH, 32, data/address width in bits; only 32 is supported.
- MEM_SIZE, 1024, depth in 32-bit words.
- NUM_PORTS, 2, number of bus channels, 1..4.
- MEM_HIGH_BIT, `HIGH_BIT_TO_FIT(MEM_SIZE-1), word-index MSB, derived.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_addr  in  NUM_PORTS*MEM_WIDTH  byte addresses; port p occupies bits [p*32+:32].
- i_dat  in  NUM_PORTS*MEM_WIDTH  write data, LSB-aligned.
- o_dat  out  NUM_PORTS*MEM_WIDTH  read data, full word.
- i_we  in  NUM_PORTS  write enable per port.
- i_stb  in  NUM_PORTS  request strobe.
- i_cyc  in  NUM_PORTS  bus cycle active.
- o_stall  out  NUM_PORTS  request not accepted this cycle.
- o_ack  out  NUM_PORTS  one-cycle completion pulse.
- o_err  out  NUM_PORTS  error qualifier, valid only with o_ack.
- i_dat_wr_size  in  NUM_PORTS*(`HIGH_BIT_TO_FIT(4)+1)  access size in bytes: 1, 2 or 4.

Behaviour:
- Reset values:
  - o_ack=0, o_err=0, o_dat=0.
  - o_stall = all ones while i_rst is high.
  - rr pointer = 0; state = STATE_INIT.
  - Memory contents are untouched by reset.
- States:
  - STATE_INIT: all o_stall=1. Moves to STATE_RUN after one cycle, or after clear completes under the optional feature.
  - STATE_RUN: normal operation.
- Port request: req[p] = i_cyc[p] & i_stb[p].
- Arbitration:
  - Combinational round-robin starting at pointer; exactly one grant among requesting ports.
  - o_stall[p] = (state!=STATE_RUN) | (req[p] & ~grant[p]).
  - An idle port sees o_stall=0 in RUN.
  - After any grant, pointer = granted port + 1, mod NUM_PORTS. No grant leaves the pointer unchanged.
- Acceptance: an access is accepted in cycle N when req[p] & ~o_stall[p]. A stalled master holds addr/data/we/size stable.
- Completion:
  - o_ack[p]=1 in cycle N+1 only.
  - o_dat[p] holds the read word in N+1.
  - For writes and errors o_dat[p]=0.
  - o_ack is low otherwise; o_dat returns to 0 when no ack.
- Throughput: one access per cycle total; back-to-back accepts from the same port are allowed.
- Word index = addr[MEM_HIGH_BIT+2:2].
- Error conditions: error ack (o_err=1, no memory write, o_dat=0) when any of these hold:
  - index >= MEM_SIZE;
  - size not in {1,2,4};
  - size=2 with addr[0]=1;
  - size=4 with addr[1:0]!=0.
- Writes:
  - size 1 writes byte lane addr[1:0] from i_dat[7:0].
  - size 2 writes half lane addr[1] from i_dat[15:0].
  - size 4 writes the full word.
  - Other bytes are preserved.
- Reads: size is checked for alignment; the full word is always returned.
- Write then read of the same word in consecutive accepted cycles: the read returns the new data.
- i_cyc dropping while an ack is pending: the ack is still issued; masters ignore it.
- Reset mid-operation: pending ack/err dropped; no write is performed in a cycle with i_rst=1.

Optional Feature:
- Macro: LEIWAND_RAM_INIT_ZERO_EN.
- Defined: STATE_INIT clears one word per cycle, index 0..MEM_SIZE-1, then enters STATE_RUN. All ports stall for exactly MEM_SIZE cycles after reset deassert.
- Undefined: STATE_INIT lasts one cycle and memory contents are unspecified.

Decomposition:
- Shared header leiwand_rv32_ram_defs.vh holds:
  - state constants STATE_INIT/STATE_RUN;
  - size codes SIZE_BYTE=1, SIZE_HALF=2, SIZE_WORD=4;
  - size-field width.
- Sub-module leiwand_rv32_rr_arbiter (NUM_PORTS; req in, grant out, pointer update on i_clk/i_rst) is natural and reusable by future bus interconnect.

Test Plan:
- Reset, then port0 write 0xDEADBEEF @0x10 size 4 → ack next cycle with err=0. Read @0x10 → o_dat=0xDEADBEEF.
- Byte write 0xAA @0x11, then half write 0x1234 @0x12, onto 0x00000000 @0x10 → read returns 0x1234AA00.
- Port0 and port1 request in the same cycle with pointer=0 → port0 granted, port1 stalled one cycle, then granted. Pointer ends at 0. Acks occur in consecutive cycles.
- Misaligned word read @0x02, half write @0x05, size 3, and address MEM_SIZE*4 → each gives ack with err=1 and memory unchanged (verify by read-back).
- Continuous requests on both ports for 8 cycles → grants alternate, 8 acks, no lost or duplicated ack.
- Assert i_rst the cycle after an accepted write → no ack, and all o_stall=1. With LEIWAND_RAM_INIT_ZERO_EN: stall for MEM_SIZE cycles, then any read returns 0.
